// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin owner selection for a shared two-digit seven-segment display.
// Every output is registered. A new owner keeps the display for at least MIN_HOLD
// cycles so the digits stay readable. Once MAX_HOLD cycles have passed, the owner
// must hand over if another requester is waiting.
// Optional feature macro: SEG_DISP_ARB_PREEMPT_EN. When it is defined, requester 0
// pre-empts any other owner.
//
// Request/grant protocol: i_req[k] is a level request. Requester k holds it high for
// as long as it wants the display. o_grant[k] (with o_owner == k) means that
// requester k's i_value slice is the one on o_value. A request seen at edge N is
// granted from edge N+1.
module seg_display_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MIN_HOLD = 25_000_000,
  parameter int MAX_HOLD = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_value,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [2:0]           o_owner,
  output logic [7:0]           o_value,
  output logic                 o_blank,
  output logic                 o_state
);

  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         ptr;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [7:0]         win_value;
  logic [NUM_REQ-1:0] win_onehot;
  logic               owner_req;
  logic [7:0]         own_value;
  logic               preempt;
  int                 d;
  int                 best_d;

  // Debug view of the FSM: 1 while some requester owns the display.
  assign o_state = (state == OWN);

  // Round-robin search starting at ptr+1. While a requester owns the display, the
  // owner is masked out, so the search can only land on a different requester.
  always_comb begin
    cand      = (state == OWN) ? (i_req & ~o_grant) : i_req;
    win_idx   = '0;
    best_d    = NUM_REQ;
    d         = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      if (cand[j] && (d < best_d)) begin
        best_d  = d;
        win_idx = 3'(j);
      end
    end
    win_found  = |cand;
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  // Pick out the winner's value slice and the current owner's slice (o_grant is one-hot).
  always_comb begin
    win_value = 8'h00;
    own_value = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_idx == 3'(j)) win_value = i_value[8*j +: 8];
      if (o_grant[j])       own_value = own_value | i_value[8*j +: 8];
    end
    owner_req = |(i_req & o_grant);
  end

  // Requester 0 may take the display from any other owner, ignoring the minimum hold.
  always_comb begin
`ifdef SEG_DISP_ARB_PREEMPT_EN
    preempt = (state == OWN) && (o_owner != 3'd0) && i_req[0];
`else
    preempt = 1'b0;
`endif
  end

  // Ownership FSM. All outputs, the hold counter and the RR pointer live in this block.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 3'(NUM_REQ - 1);
      o_grant <= '0;
      o_owner <= 3'd0;
      o_value <= 8'h00;
      o_blank <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= OWN;
            o_grant <= win_onehot;
            o_owner <= win_idx;
            o_value <= win_value;
            o_blank <= 1'b0;
            cnt     <= '0;
            ptr     <= win_idx;
          end
        end
        OWN: begin
          if (preempt) begin
            o_grant <= NUM_REQ'(1);
            o_owner <= 3'd0;
            o_value <= i_value[7:0];
            cnt     <= '0;
            ptr     <= 3'd0;
          end else if (!owner_req && (cnt >= MIN_LIM)) begin
            if (win_found) begin
              o_grant <= win_onehot;
              o_owner <= win_idx;
              o_value <= win_value;
              cnt     <= '0;
              ptr     <= win_idx;
            end else begin
              state   <= IDLE;
              o_grant <= '0;
              o_owner <= 3'd0;
              o_value <= 8'h00;
              o_blank <= 1'b1;
              cnt     <= '0;
            end
          end else if ((cnt >= MAX_LIM) && owner_req && win_found) begin
            o_grant <= win_onehot;
            o_owner <= win_idx;
            o_value <= win_value;
            cnt     <= '0;
            ptr     <= win_idx;
          end else begin
            if (cnt != MAX_LIM) cnt <= cnt + 1'b1;
            // While the owner's request is low, o_value keeps its last value.
            if (owner_req) o_value <= own_value;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter with NUM_REQ=4, MIN_HOLD=4, MAX_HOLD=10.
module tb_seg_display_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [31:0] i_value;
  logic [3:0]  o_grant;
  logic [2:0]  o_owner;
  logic [7:0]  o_value;
  logic        o_blank;
  logic        o_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] v0;
    logic [3:0] grant;
    logic [2:0] owner;
    logic [7:0] value;
    logic       blank;
  } vec_t;

  vec_t vecs[15];

  seg_display_arbiter #(
    .NUM_REQ (4),
    .MIN_HOLD(4),
    .MAX_HOLD(10),
    .CNT_W   (4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_value(i_value),
    .o_grant(o_grant),
    .o_owner(o_owner),
    .o_value(o_value),
    .o_blank(o_blank),
    .o_state(o_state)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] req, input logic [7:0] v0);
    i_req   = req;
    i_value = {8'h33, 8'h22, 8'h11, v0};
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] g, input logic [2:0] own,
                           input logic [7:0] val, input logic blank);
    check({name, ".grant"}, 32'(o_grant), 32'(g));
    check({name, ".owner"}, 32'(o_owner), 32'(own));
    check({name, ".value"}, 32'(o_value), 32'(val));
    check({name, ".blank"}, 32'(o_blank), 32'(blank));
  endtask

  initial begin
    // Vector table: {req, value0} applied, then the outputs expected after the next edge
    vecs[0]  = '{4'b0000, 8'h3C, 4'b0000, 3'd0, 8'h00, 1'b1};
    vecs[1]  = '{4'b0001, 8'h3C, 4'b0001, 3'd0, 8'h3C, 1'b0};
    vecs[2]  = '{4'b0001, 8'h3D, 4'b0001, 3'd0, 8'h3D, 1'b0};
    vecs[3]  = '{4'b0000, 8'h3D, 4'b0001, 3'd0, 8'h3D, 1'b0};
    vecs[4]  = '{4'b0000, 8'h55, 4'b0001, 3'd0, 8'h3D, 1'b0};
    vecs[5]  = '{4'b0000, 8'h55, 4'b0000, 3'd0, 8'h00, 1'b1};
    vecs[6]  = '{4'b0110, 8'h55, 4'b0010, 3'd1, 8'h11, 1'b0};
    vecs[7]  = '{4'b1001, 8'h55, 4'b0010, 3'd1, 8'h11, 1'b0};
    vecs[8]  = '{4'b1001, 8'h55, 4'b0010, 3'd1, 8'h11, 1'b0};
    vecs[9]  = '{4'b1001, 8'h55, 4'b0010, 3'd1, 8'h11, 1'b0};
    vecs[10] = '{4'b1001, 8'h55, 4'b1000, 3'd3, 8'h33, 1'b0};
    vecs[11] = '{4'b0001, 8'h55, 4'b1000, 3'd3, 8'h33, 1'b0};
    vecs[12] = '{4'b0001, 8'h55, 4'b1000, 3'd3, 8'h33, 1'b0};
    vecs[13] = '{4'b0001, 8'h55, 4'b1000, 3'd3, 8'h33, 1'b0};
    vecs[14] = '{4'b0001, 8'h66, 4'b0001, 3'd0, 8'h66, 1'b0};

    // Reset state
    i_rst = 1'b1;
    set_in(4'b0000, 8'h00);
    #3;
    check_all("reset", 4'b0000, 3'd0, 8'h00, 1'b1);
    check("reset.state", 32'(o_state), 32'd0);
    tick();
    i_rst = 1'b0;

    // Table: first grant, value tracking, freeze, MIN_HOLD release, RR after owner 3
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].req, vecs[i].v0);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].value, vecs[i].blank);
    end

    // Requesters 0 and 2 held: MAX_HOLD handover every 10 cycles, never blank
    set_in(4'b0101, 8'h66);
    for (int t = 1; t <= 30; t++) begin
      tick();
      check($sformatf("alt%0d.grant", t), 32'(o_grant),
            (((t / 10) % 2) == 0) ? 32'h1 : 32'h4);
      check($sformatf("alt%0d.blank", t), 32'(o_blank), 32'd0);
    end

    // Owner 2 at cnt=1, requester 0 rises
    set_in(4'b0100, 8'h66);
    tick();
    check("pre.grant", 32'(o_grant), 32'h4);
    set_in(4'b0101, 8'h66);
`ifdef SEG_DISP_ARB_PREEMPT_EN
    tick();
    check_all("preempt", 4'b0001, 3'd0, 8'h66, 1'b0);
`else
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("nopre%0d.grant", k), 32'(o_grant), 32'h4);
    end
    tick();
    check_all("nopre.handover", 4'b0001, 3'd0, 8'h66, 1'b0);
`endif

    // Async reset mid-OWN takes effect without a clock edge
    #2;
    i_rst = 1'b1;
    #1;
    check_all("midrst", 4'b0000, 3'd0, 8'h00, 1'b1);
    tick();
    i_rst = 1'b0;
    set_in(4'b1001, 8'hA5);
    tick();
    check_all("after_rst", 4'b0001, 3'd0, 8'hA5, 1'b0);

    // Sole requester kept past MAX_HOLD, then immediate handover from the saturated count
    for (int k = 0; k < 14; k++) begin
      set_in(4'b0001, 8'(k));
      tick();
      check($sformatf("sole%0d.grant", k), 32'(o_grant), 32'h1);
      check($sformatf("sole%0d.value", k), 32'(o_value), 32'(k));
    end
    set_in(4'b0101, 8'h77);
    tick();
    check_all("sat_handover", 4'b0100, 3'd2, 8'h22, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
